// File: rtl/rdr_pkg.sv
// Shared definitions for the burst RAM reader: FSM state encoding, default geometry and
// output-buffer depth.
package rdr_pkg;

    localparam int unsigned DefAddrW  = 13;
    localparam int unsigned DefStep   = 4;
    localparam int unsigned FifoDepth = 2;
    localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } rdr_state_e;

endpackage

// File: rtl/rdr_fifo.sv
// Small output buffer for ram_reader: FifoDepth entries, push/pop with count and flags.
// The head word reads as zero while the buffer is empty.
module rdr_fifo
    import rdr_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic [Width-1:0]    wdata_i,
    input  logic                pop_i,
    output logic [Width-1:0]    rdata_o,
    output logic [FifoCntW-1:0] count_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);

    logic [Width-1:0]    mem_q [FifoDepth];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [FifoCntW-1:0] count_q, count_d;
    logic                do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FifoCntW'(FifoDepth));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + FifoCntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - FifoCntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ram_reader.sv
// Burst reader: issues len sequential word reads from a 1-cycle-latency RAM and streams the
// data through a 2-entry buffer. Define RAM_READER_STALL_CNT_EN to add the stall_cnt_o port.
module ram_reader
    import rdr_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned STEP   = DefStep,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              ren_o,
    output logic [ADDR_W-1:0] r_addr_o,
    input  logic [31:0]       rdata_i,
    output logic [31:0]       data_out_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              busy_o,
    output logic              done_o
`ifdef RAM_READER_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    localparam int unsigned CrW = FifoCntW + 1;

    rdr_state_e          state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    remaining_q;
    logic                inflight_q;
    logic                zero_done_q;

    logic [FifoCntW-1:0] fifo_count;
    logic                fifo_full, fifo_empty;
    logic                pop, drain_done;
    logic [CrW-1:0]      credit_used;

    assign pop          = data_valid_o & data_ready_i;
    assign credit_used  = CrW'(fifo_count) + CrW'(inflight_q);
    // A same-cycle pop frees a slot before the new read's data lands, sustaining 1 word/cycle.
    assign ren_o        = (state_q == StRun) && (credit_used < CrW'(FifoDepth) + CrW'(pop));
    assign r_addr_o     = addr_q;
    assign data_valid_o = ~fifo_empty;
    assign busy_o       = (state_q != StIdle);
    assign drain_done   = (state_q == StDrain) && fifo_empty && !inflight_q;
    assign done_o       = drain_done | zero_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            inflight_q  <= ren_o;
            zero_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            state_q     <= StRun;
                            addr_q      <= base_addr_i;
                            remaining_q <= len_i;
                        end else begin
                            zero_done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (ren_o) begin
                        addr_q      <= addr_q + ADDR_W'(STEP);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    rdr_fifo #(
        .Width (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .wdata_i (rdata_i),
        .pop_i   (pop),
        .rdata_o (data_out_o),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Credit accounting must never let returning data meet a full, non-draining buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(inflight_q && fifo_full && !pop));

`ifdef RAM_READER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == StIdle && start_i) begin
            stall_cnt_d = '0;
        end else if (data_valid_o && !data_ready_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
